// File: rtl/sig_pkg.sv
// Shared definitions for the signal saver / signal loader pair:
// frame geometry, word size and the frame-engine state encoding.
package sig_pkg;

  localparam int SAMPLES_PER_FRAME = 320;
  localparam int WORD_BYTES        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sig_state_t;

  // Select one 16-bit sample from a packed word; the low half is the earlier sample.
  function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/sig_unpack.sv
// Two-word buffer (out + pre) that splits 32-bit words into a stream of
// 16-bit samples, low half first, on a valid/ready interface.
module sig_unpack
  import sig_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic [31:0] i_word_in,
  input  logic        i_word_we,
  input  logic        i_profile_rdy,
  output logic [15:0] o_profile_data,
  output logic        o_profile_valid,
  output logic        o_can_accept,
  output logic        o_hs
);

  logic [31:0] r_out_word;
  logic [31:0] r_pre_word;
  logic        r_out_valid;
  logic        r_pre_valid;
  logic        r_half;
  logic        w_hs;
  logic        w_drain;
  logic        w_to_out;

  // Valid/ready: a sample transfers in any cycle where valid and ready are both
  // high; valid and data never change while valid=1 and ready=0.
  assign w_hs     = r_out_valid & i_profile_rdy;
  assign w_drain  = w_hs & r_half;
  assign w_to_out = ~r_out_valid | (w_drain & ~r_pre_valid);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_out_word  <= '0;
      r_pre_word  <= '0;
      r_out_valid <= 1'b0;
      r_pre_valid <= 1'b0;
      r_half      <= 1'b0;
    end else begin
      if (w_hs) r_half <= ~r_half;
      if (w_drain) begin
        r_out_word  <= r_pre_word;
        r_out_valid <= r_pre_valid;
        r_pre_valid <= 1'b0;
      end
      // A new word lands in out when it is free (or freed now with nothing
      // queued behind it); otherwise it waits in pre.
      if (i_word_we) begin
        if (w_to_out) begin
          r_out_word  <= i_word_in;
          r_out_valid <= 1'b1;
        end else begin
          r_pre_word  <= i_word_in;
          r_pre_valid <= 1'b1;
        end
      end
    end
  end

  assign o_profile_data  = half_sel(r_out_word, r_half);
  assign o_profile_valid = r_out_valid;
  assign o_can_accept    = ~r_pre_valid;
  assign o_hs            = w_hs;

endmodule

// File: rtl/sig_loader.sv
// Frame loader: reads SAMPLES/2 words by single-word DMA and streams them out
// as SAMPLES 16-bit samples, then pulses irq.
module sig_loader
  import sig_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_PER_FRAME,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr_read,
  output logic [31:0] dma1_addr,
  output logic        dma1_read,
  output logic        dma1_write,
  output logic [31:0] dma1_writedata,
  input  logic [31:0] dma_readdata,
  input  logic        dma_rdy,
  output logic [15:0] profile_data,
  output logic        profile_valid,
  input  logic        profile_rdy,
  output logic        busy,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] WORDS     = CNT_W'(SAMPLES / 2);
  localparam logic [CNT_W-1:0] LAST_SMP  = CNT_W'(SAMPLES - 1);
  localparam logic [31:0]      ADDR_STEP = 32'(WORD_BYTES);

  sig_state_t       r_state;
  sig_state_t       w_state_nxt;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_req_cnt;
  logic [CNT_W-1:0] r_smp_cnt;
  logic             r_pending;
  logic             w_start_acc;
  logic             w_rd;
  logic             w_rsp;
  logic             w_hs;
  logic             w_can_accept;
  logic             w_last_hs;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  // A strobe with nothing outstanding (idle, or after a reset) is dropped here.
  assign w_rsp       = dma_rdy && r_pending;
  assign w_last_hs   = w_hs && (r_smp_cnt == LAST_SMP);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_hs) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One read in flight at most, and only when pre has room for its data.
  always_comb begin
    w_rd      = (r_state == ST_RUN) && !r_pending && w_can_accept && (r_req_cnt < WORDS);
    dma1_read = w_rd;
    dma1_addr = w_rd ? r_addr : '0;
    busy      = (r_state != ST_IDLE);
    irq       = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_req_cnt <= '0;
      r_smp_cnt <= '0;
      r_pending <= 1'b0;
    end else if (w_start_acc) begin
      r_addr    <= start_addr_read;
      r_req_cnt <= '0;
      r_smp_cnt <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_rd) begin
        r_addr    <= r_addr + ADDR_STEP;
        r_req_cnt <= r_req_cnt + CNT_W'(1);
        r_pending <= 1'b1;
      end else if (w_rsp) begin
        r_pending <= 1'b0;
      end
      if (w_hs) r_smp_cnt <= r_smp_cnt + CNT_W'(1);
    end
  end

  sig_unpack u_unpack (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (w_start_acc),
    .i_word_in       (dma_readdata),
    .i_word_we       (w_rsp),
    .i_profile_rdy   (profile_rdy),
    .o_profile_data  (profile_data),
    .o_profile_valid (profile_valid),
    .o_can_accept    (w_can_accept),
    .o_hs            (w_hs)
  );

  assign dma1_write     = 1'b0;
  assign dma1_writedata = '0;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_sig_loader.sv
// Bench for sig_loader: frame vectors from a table plus hand-written sequences
// for reset abort, spurious strobes and a two-sample build.
module tb_sig_loader;
  import sig_pkg::*;

  localparam int SMP = 320;
  localparam int WRD = 160;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (SAMPLES=320) ----------------
  logic        start = 1'b0;
  logic [31:0] start_addr_read = '0;
  logic [31:0] dma1_addr;
  logic        dma1_read;
  logic        dma1_write;
  logic [31:0] dma1_writedata;
  logic [31:0] dma_readdata = '0;
  logic        dma_rdy = 1'b0;
  logic [15:0] profile_data;
  logic        profile_valid;
  logic        profile_rdy = 1'b0;
  logic        busy;
  logic        irq;
  logic [1:0]  dbg_state;

  sig_loader #(.SAMPLES(SMP), .CNT_W(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_addr_read(start_addr_read),
    .dma1_addr(dma1_addr), .dma1_read(dma1_read), .dma1_write(dma1_write),
    .dma1_writedata(dma1_writedata), .dma_readdata(dma_readdata), .dma_rdy(dma_rdy),
    .profile_data(profile_data), .profile_valid(profile_valid), .profile_rdy(profile_rdy),
    .busy(busy), .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- DUT (SAMPLES=2) ----------------
  logic        s2_start = 1'b0;
  logic [31:0] s2_addr_in = '0;
  logic [31:0] s2_addr;
  logic        s2_read;
  logic        s2_write;
  logic [31:0] s2_wdata;
  logic [31:0] s2_rdata = '0;
  logic        s2_rdy = 1'b0;
  logic [15:0] s2_data;
  logic        s2_valid;
  logic        s2_prdy = 1'b1;
  logic        s2_busy;
  logic        s2_irq;
  logic [1:0]  s2_state;

  sig_loader #(.SAMPLES(2), .CNT_W(10)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .start_addr_read(s2_addr_in),
    .dma1_addr(s2_addr), .dma1_read(s2_read), .dma1_write(s2_write),
    .dma1_writedata(s2_wdata), .dma_readdata(s2_rdata), .dma_rdy(s2_rdy),
    .profile_data(s2_data), .profile_valid(s2_valid), .profile_rdy(s2_prdy),
    .busy(s2_busy), .irq(s2_irq), .dbg_state(s2_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory responder + scoreboard ----------------
  logic [31:0] base = '0;
  int          lat = 2;
  int          bp_mode = 0;
  bit          resp_en = 1'b0;
  int          cd = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] last_addr = '0;
  int          nreads = 0, rcvd = 0, smp_seen = 0, irq_cnt = 0, drops = 0;
  int          cyc = 0, last_hs_cyc = -10;
  bit          prev_v = 1'b0, prev_r = 1'b0;
  logic [15:0] prev_d = '0;
  logic [15:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = (a - base) >> 2;
    return {k[14:0], 1'b1, k[14:0], 1'b0};
  endfunction

  initial begin
    logic        rdy_now;
    logic [31:0] word;
    logic [15:0] e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      rdy_now = 1'b0;
      word    = '0;
      if (resp_en && cd > 0) begin
        cd--;
        if (cd == 0) begin
          rdy_now = 1'b1;
          word    = mem_word(rd_addr);
        end
      end
      if (dma1_read) begin
        chk("rd_one_outstanding", (cd != 0) || rdy_now, 1'b0);
        chk("rd_while_pre_full", (rcvd - smp_seen / 2) >= 2, 1'b0);
        chk("rd_addr", dma1_addr, base + 32'(4 * nreads));
        chk("rd_count_limit", nreads < WRD, 1'b1);
        chk("rd_busy", busy, 1'b1);
        last_addr = dma1_addr;
        rd_addr   = dma1_addr;
        nreads++;
        cd = lat;
      end
      if (resp_en) begin
        dma_rdy      = rdy_now;
        dma_readdata = word;
        if (rdy_now) begin
          exp_q.push_back(word[15:0]);
          exp_q.push_back(word[31:16]);
          rcvd++;
        end
      end
      if (prev_v && !prev_r) begin
        chk("stall_valid", profile_valid, 1'b1);
        chk("stall_data", profile_data, prev_d);
      end
      if (prev_v && !profile_valid) drops++;
      profile_rdy = (bp_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (profile_valid && profile_rdy) begin
        if (exp_q.size() == 0) chk("extra_sample", profile_data, 16'hxxxx);
        else begin
          e = exp_q.pop_front();
          chk("sample", profile_data, e);
        end
        smp_seen++;
        if (smp_seen == SMP) last_hs_cyc = cyc;
      end
      if (irq) begin
        irq_cnt++;
        chk("irq_timing", cyc, last_hs_cyc + 1);
        chk("done_no_valid", profile_valid, 1'b0);
        chk("irq_busy", busy, 1'b1);
      end
      prev_v = profile_valid;
      prev_r = profile_rdy;
      prev_d = profile_data;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [31:0] base;
    int          lat;
    int          bp;
    bit          hold;
    logic [31:0] exp_last;
    int          exp_drops;
  } vec_t;

  task automatic frame_init(input logic [31:0] b, input int l, input int m);
    base = b; lat = l; bp_mode = m; cd = 0;
    nreads = 0; rcvd = 0; smp_seen = 0; irq_cnt = 0; drops = 0;
    last_hs_cyc = -10; prev_v = 1'b0; prev_r = 1'b0;
    exp_q.delete();
    resp_en = 1'b1;
    start_addr_read = b;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    frame_init(v.base, v.lat, v.bp);
    start = 1'b1;
    if (!v.hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 20000 && irq_cnt == 0; i++) @(negedge clk);
    chk("frame_timeout", irq_cnt != 0, 1'b1);
    // In the DONE cycle now: start here must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("end_busy", busy, 1'b0);
    chk("end_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("end_reads", nreads, WRD);
    chk("end_last_addr", last_addr, v.exp_last);
    chk("end_samples", smp_seen, SMP);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_irq_count", irq_cnt, 1);
    if (v.exp_drops >= 0) chk("slow_valid_drops", drops, v.exp_drops);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[4];
  vec_t v_after;

  initial begin
    vecs[0] = '{base: 32'h0000_1000, lat: 2,  bp: 0, hold: 1'b0, exp_last: 32'h0000_127C, exp_drops: -1};
    vecs[1] = '{base: 32'h0000_3000, lat: 2,  bp: 1, hold: 1'b0, exp_last: 32'h0000_327C, exp_drops: -1};
    vecs[2] = '{base: 32'h0000_4000, lat: 20, bp: 0, hold: 1'b0, exp_last: 32'h0000_427C, exp_drops: 160};
    vecs[3] = '{base: 32'hFFFF_FF00, lat: 1,  bp: 1, hold: 1'b1, exp_last: 32'h0000_017C, exp_drops: -1};

    repeat (3) @(negedge clk);
    chk("rst_read", dma1_read, 1'b0);
    chk("rst_addr", dma1_addr, 32'h0);
    chk("rst_write", dma1_write, 1'b0);
    chk("rst_wdata", dma1_writedata, 32'h0);
    chk("rst_valid", profile_valid, 1'b0);
    chk("rst_data", profile_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst2_valid", s2_valid, 1'b0);
    rst = 1'b0;

    // Spurious completion strobe while idle.
    @(negedge clk);
    dma_rdy = 1'b1;
    dma_readdata = 32'h1234_5678;
    @(negedge clk);
    dma_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_strobe_quiet", {profile_valid, busy, dma1_read, irq}, 4'b0000);
    end

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame while a read is outstanding.
    @(negedge clk);
    frame_init(32'h0000_1000, 2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5000 && !(smp_seen >= 57 && cd > 0); i++) @(negedge clk);
    chk("abort_reach_point", smp_seen >= 57 && cd > 0, 1'b1);
    rst = 1'b1; resp_en = 1'b0; cd = 0; dma_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_read", dma1_read, 1'b0);
    chk("abort_addr", dma1_addr, 32'h0);
    chk("abort_valid", profile_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_irq", irq, 1'b0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    exp_q.delete();
    prev_v = 1'b0;
    @(negedge clk);
    dma_rdy = 1'b1;
    dma_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dma_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("late_rdy_ignored", {profile_valid, busy, dma1_read, irq}, 4'b0000);
    end
    chk("abort_no_irq", irq_cnt, 0);
    v_after = '{base: 32'h0000_2000, lat: 2, bp: 0, hold: 1'b0, exp_last: 32'h0000_227C, exp_drops: -1};
    run_vec(v_after);

    // Two-sample build: one read, samples 0 then 1, then irq.
    @(negedge clk);
    s2_addr_in = 32'h0000_0500;
    s2_start = 1'b1;
    @(negedge clk);
    s2_start = 1'b0;
    chk("s2_read", s2_read, 1'b1);
    chk("s2_addr", s2_addr, 32'h0000_0500);
    chk("s2_busy", s2_busy, 1'b1);
    @(negedge clk);
    chk("s2_wait_read", s2_read, 1'b0);
    chk("s2_wait_valid", s2_valid, 1'b0);
    s2_rdy = 1'b1;
    s2_rdata = 32'h0001_0000;
    @(negedge clk);
    s2_rdy = 1'b0;
    s2_rdata = 32'h0;
    chk("s2_valid0", s2_valid, 1'b1);
    chk("s2_sample0", s2_data, 16'h0000);
    chk("s2_no_second_read", s2_read, 1'b0);
    @(negedge clk);
    chk("s2_valid1", s2_valid, 1'b1);
    chk("s2_sample1", s2_data, 16'h0001);
    @(negedge clk);
    chk("s2_irq", s2_irq, 1'b1);
    chk("s2_done_valid", s2_valid, 1'b0);
    @(negedge clk);
    chk("s2_irq_end", s2_irq, 1'b0);
    chk("s2_idle", {s2_busy, s2_read, s2_valid}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sig_loader.md
Name: sig_loader

Overview:
- Read-side counterpart of the signal saver.
- On `start`, issues single-word DMA reads from `start_addr_read` and unpacks each 32-bit word into two 16-bit samples, low half first.
- Delivers the samples on a valid/ready profile stream and pulses `irq` after SAMPLES samples have been accepted.
- Feeds stored signal frames back into the processing chain for replay and inference.

Parameters:
- SAMPLES, 320: samples per frame. Must be even and at least 2; word count is SAMPLES/2.
- CNT_W, 10: width of the sample and word counters. Must satisfy 2^CNT_W > SAMPLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- start_addr_read  in  32  byte address of the first word; latched on accepted start
- dma1_addr  out  32  read address; 0 when dma1_read=0
- dma1_read  out  1  one-cycle read request
- dma1_write  out  1  tied 0
- dma1_writedata  out  32  tied 0
- dma_readdata  in  32  read data, valid in the cycle dma_rdy=1
- dma_rdy  in  1  completion strobe for the outstanding read
- profile_data  out  16  sample
- profile_valid  out  1  sample available
- profile_rdy  in  1  consumer accepts when profile_valid and profile_rdy are both 1
- busy  out  1  high from the cycle after an accepted start until the irq cycle inclusive
- irq  out  1  one-cycle done pulse

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: all outputs 0; state IDLE; counters, address, both word buffers and their flags cleared; pending flag cleared.
- Reset mid-frame: abort with no irq. A `dma_rdy` arriving after reset is ignored because pending=0.

States:
- IDLE: on start, latch addr=start_addr_read, req_cnt=0, smp_cnt=0, clear buffers, go to RUN. start in any other state is ignored.
- RUN: request and stream logic below. When the SAMPLES-th handshake occurs, go to DONE.
- DONE: irq=1 for exactly one cycle, then IDLE. A start seen in the DONE cycle is ignored.

Request rule (RUN), combinational:
- dma1_read=1 when pending=0, pre_valid=0, and req_cnt < SAMPLES/2.
- In that cycle: dma1_addr=addr. Next cycle: addr+=4 (32-bit wrap allowed), req_cnt+=1, pending=1.
- At most one read outstanding at any time.

Response rule:
- dma_rdy with pending=1 clears pending.
- dma_readdata is written to out_word if the output stage is empty or being emptied in this same cycle; otherwise it is written to pre_word and pre_valid is set.
- dma_rdy with pending=0 is ignored.

Stream rule:
- profile_valid = out_valid.
- profile_data = out_word[15:0] when half=0, out_word[31:16] when half=1.
- Data is held stable while valid=1 and rdy=0.
- On each handshake: smp_cnt+=1 and half toggles.
- On the handshake where half=1, the output stage empties, and pre_word, if valid, moves to out_word in the same cycle.
- Back-to-back handshakes are sustained every cycle while buffered data exists.

Latency and buffering:
- Start accepted at cycle T: dma1_read at T+1.
- dma_rdy at cycle R: profile_valid at R+1 at the earliest.
- Buffering is at most 2 words (out + pre); no overflow is possible because a request requires pre_valid=0.

Frame end:
- No request is issued after req_cnt reaches SAMPLES/2.
- DONE is entered on the SAMPLES-th handshake. No stray sample is presented: profile_valid=0 in DONE.

Decomposition:
- Package sig_pkg:
  - SAMPLES_PER_FRAME=320, WORD_BYTES=4
  - state encoding IDLE/RUN/DONE
  - shared with the signal saver
- Sub-module sig_unpack:
  - holds out_word/pre_word, the valid flags and the half bit
  - inputs: word_in, word_we
  - outputs: profile_* and can_accept (=!pre_valid)
  - the top block keeps the FSM, counters, address and DMA request logic.

Test Plan:
- Basic frame:
  - Stimulus: start_addr_read=0x1000, memory word k = {16'(2k+1), 16'(2k)}, dma_rdy 2 cycles after each read, profile_rdy=1.
  - Response: 160 reads at 0x1000..0x127C in step 4; samples 0,1,...,319 in order; exactly one irq pulse, 1 cycle after the 320th handshake.
- Backpressure:
  - Stimulus: profile_rdy toggled pseudo-randomly.
  - Response: profile_data stable while stalled; no sample lost or duplicated; dma1_read never issued while pre_valid=1.
- Slow memory:
  - Stimulus: dma_rdy 20 cycles after each read.
  - Response: profile_valid drops between words; pending never exceeds 1; 320 samples and 1 irq.
- Reset mid-frame:
  - Stimulus: assert rst after 57 samples, while a read is outstanding; later pulse dma_rdy.
  - Response: outputs 0, no irq; the late dma_rdy is ignored; a new start at 0x2000 produces a correct full frame.
- Protocol edges:
  - Stimulus: start held high throughout; a spurious dma_rdy in IDLE; SAMPLES=2 build.
  - Response: only one frame runs per IDLE entry; the spurious strobe has no effect; the SAMPLES=2 build issues a single read, yields samples 0 then 1, then irq.
